// File: rtl/digit_pkg.sv
// Shared types and constants for the single-digit counter and its segment decoder.
package digit_pkg;

   localparam int WIDTH = 4;

   typedef enum logic {
      RUN   = 1'b0,
      PAUSE = 1'b1
   } state_t;

   // Active-low glyphs, bit 6 = a ... bit 0 = g; entry 15 first, entry 0 last.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
      7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
   };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low seven-segment lookup.
module seg7_decode
   import digit_pkg::*;
(
   input  logic [WIDTH-1:0] digit,
   output logic [6:0]       seg
);

   // straight table lookup, bit order a..g
   always_comb begin
      seg = SEG_TABLE[digit];
   end

endmodule

// File: rtl/digit_counter_7seg.sv
// Single-digit up/down counter with prescaler, pause button and 7-segment output.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | enabled ticks advance the prescaler and step the digit
//   PAUSE | prescaler and digit hold, cnt_en ignored, carry stays 0
//
module digit_counter_7seg
   import digit_pkg::*;
#(
   parameter int MODULUS = 10,
   parameter int DIV     = 1
)
(
   input  logic             clock,
   input  logic             KEY0,
   input  logic             KEY1,
   input  logic             cnt_en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             carry,
   output logic             running,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   output logic             e,
   output logic             f,
   output logic             g
);

   localparam int               PW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [PW-1:0]    PRE_TC  = PW'(DIV - 1);

   state_t           state_q;
   state_t           state_nxt;
   logic             key1_s1;
   logic             key1_s2;
   logic             key1_prev;
   logic             press;
   logic [PW-1:0]    presc_q;
   logic [PW-1:0]    presc_nxt;
   logic [WIDTH-1:0] value_nxt;
   logic             carry_nxt;
   logic [6:0]       seg_nxt;
   logic [6:0]       seg_q;

   // two-flop synchroniser on the button plus a delayed copy for edge detect
   always_ff @(posedge clock or negedge KEY0) begin
      if (!KEY0) begin
         key1_s1   <= 1'b1;
         key1_s2   <= 1'b1;
         key1_prev <= 1'b1;
      end else begin
         key1_s1   <= KEY1;
         key1_s2   <= key1_s1;
         key1_prev <= key1_s2;
      end
   end

   // a press is the high-to-low transition of the synchronised button
   assign press = key1_prev & ~key1_s2;

   // run/pause state register
   always_ff @(posedge clock or negedge KEY0) begin
      if (!KEY0) begin
         state_q <= RUN;
      end else begin
         state_q <= state_nxt;
      end
   end

   // each press flips between RUN and PAUSE
   always_comb begin
      state_nxt = state_q;
      if (press) begin
         case (state_q)
            RUN:     state_nxt = PAUSE;
            PAUSE:   state_nxt = RUN;
            default: state_nxt = RUN;
         endcase
      end
   end

   // next digit, prescaler and carry: clear over load over step
   always_comb begin
      value_nxt = value;
      presc_nxt = presc_q;
      carry_nxt = 1'b0;
      if (clear) begin
         value_nxt = '0;
         presc_nxt = '0;
      end else if (load) begin
         value_nxt = (load_value > MAX_VAL) ? MAX_VAL : load_value;
         presc_nxt = '0;
      end else if ((state_q == RUN) && cnt_en) begin
         if (presc_q == PRE_TC) begin
            presc_nxt = '0;
            if (up) begin
               if (value == MAX_VAL) begin
                  value_nxt = '0;
                  carry_nxt = 1'b1;
               end else begin
                  value_nxt = value + WIDTH'(1);
               end
            end else begin
               if (value == '0) begin
                  value_nxt = MAX_VAL;
                  carry_nxt = 1'b1;
               end else begin
                  value_nxt = value - WIDTH'(1);
               end
            end
         end else begin
            presc_nxt = presc_q + PW'(1);
         end
      end
   end

   // segments decode the next value so they update on the same edge as value
   seg7_decode u_seg7_decode (
      .digit (value_nxt),
      .seg   (seg_nxt)
   );

   // digit, prescaler, carry and segment registers
   always_ff @(posedge clock or negedge KEY0) begin
      if (!KEY0) begin
         value   <= '0;
         presc_q <= '0;
         carry   <= 1'b0;
         seg_q   <= SEG_TABLE[0];
      end else begin
         value   <= value_nxt;
         presc_q <= presc_nxt;
         carry   <= carry_nxt;
         seg_q   <= seg_nxt;
      end
   end

   assign running = (state_q == RUN);
   assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_digit_counter_7seg.sv
// Self-checking bench: three counter instances share stimulus and are compared each cycle
// against an arithmetic reference model, plus directed vectors and hand-written sequences.
module tb_digit_counter_7seg;

   logic       clock = 1'b0;
   logic       KEY0;
   logic       KEY1;
   logic       cnt_en;
   logic       up;
   logic       clear;
   logic       load;
   logic [3:0] load_value;

   logic [3:0] v0, v1, v2;
   logic       c0, c1, c2;
   logic       r0, r1, r2;
   logic [6:0] s0, s1, s2;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   localparam int MODS [3] = '{10, 6, 16};
   localparam int DIVS [3] = '{1, 1, 4};

   always #5 clock = ~clock;

   digit_counter_7seg #(.MODULUS(10), .DIV(1)) dut_a (
      .clock(clock), .KEY0(KEY0), .KEY1(KEY1), .cnt_en(cnt_en), .up(up),
      .clear(clear), .load(load), .load_value(load_value),
      .value(v0), .carry(c0), .running(r0),
      .a(s0[6]), .b(s0[5]), .c(s0[4]), .d(s0[3]), .e(s0[2]), .f(s0[1]), .g(s0[0])
   );

   digit_counter_7seg #(.MODULUS(6), .DIV(1)) dut_b (
      .clock(clock), .KEY0(KEY0), .KEY1(KEY1), .cnt_en(cnt_en), .up(up),
      .clear(clear), .load(load), .load_value(load_value),
      .value(v1), .carry(c1), .running(r1),
      .a(s1[6]), .b(s1[5]), .c(s1[4]), .d(s1[3]), .e(s1[2]), .f(s1[1]), .g(s1[0])
   );

   digit_counter_7seg #(.MODULUS(16), .DIV(4)) dut_c (
      .clock(clock), .KEY0(KEY0), .KEY1(KEY1), .cnt_en(cnt_en), .up(up),
      .clear(clear), .load(load), .load_value(load_value),
      .value(v2), .carry(c2), .running(r2),
      .a(s2[6]), .b(s2[5]), .c(s2[4]), .d(s2[3]), .e(s2[2]), .f(s2[1]), .g(s2[0])
   );

   // lit segments of each glyph, written as letters
   string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   function automatic logic [6:0] seg_of(int v);
      logic [6:0] m;
      string      s;
      m = '0;
      s = glyph[v];
      for (int k = 0; k < s.len(); k++) begin
         m[6 - (int'(s[k]) - 97)] = 1'b1;
      end
      return ~m;
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // reference model: tick count modulo DIV, digit modulo MODULUS, button from sample history
   int mval [3];
   int mpre [3];
   bit mcar [3];
   bit mrun;
   bit h1, h2, h3;

   always @(posedge clock or negedge KEY0) begin : model
      bit run_old;
      if (!KEY0) begin
         for (int i = 0; i < 3; i++) begin
            mval[i] = 0;
            mpre[i] = 0;
            mcar[i] = 1'b0;
         end
         mrun = 1'b1;
         h1 = 1'b1;
         h2 = 1'b1;
         h3 = 1'b1;
      end else begin
         run_old = mrun;
         // a press seen by the sampler toggles the mode two edges later
         if (!h2 && h3) mrun = !mrun;
         h3 = h2;
         h2 = h1;
         h1 = KEY1;
         for (int i = 0; i < 3; i++) begin
            mcar[i] = 1'b0;
            if (clear) begin
               mval[i] = 0;
               mpre[i] = 0;
            end else if (load) begin
               mval[i] = (int'(load_value) >= MODS[i]) ? MODS[i] - 1 : int'(load_value);
               mpre[i] = 0;
            end else if (run_old && cnt_en) begin
               mpre[i] = (mpre[i] + 1) % DIVS[i];
               if (mpre[i] == 0) begin
                  mval[i] = (mval[i] + (up ? 1 : MODS[i] - 1)) % MODS[i];
                  mcar[i] = up ? (mval[i] == 0) : (mval[i] == MODS[i] - 1);
               end
            end
         end
      end
   end

   task automatic check_inst(string n, int i, logic [3:0] v, logic c, logic r, logic [6:0] s);
      chk({n, ".value"},   32'(v), 32'(mval[i]));
      chk({n, ".carry"},   32'(c), 32'(mcar[i]));
      chk({n, ".running"}, 32'(r), 32'(mrun));
      chk({n, ".seg"},     32'(s), 32'(seg_of(mval[i])));
   endtask

   // compare every instance against the model on the falling edge
   always @(negedge clock) begin
      if (chk_on) begin
         check_inst("a", 0, v0, c0, r0, s0);
         check_inst("b", 1, v1, c1, r1, s1);
         check_inst("c", 2, v2, c2, r2, s2);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      bit en;
      bit upd;
      bit clr;
      bit ld;
      int lv;
      int ev;
      bit ec;
   } vec_t;

   vec_t tbl [20];

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // directed vectors for the MODULUS=10, DIV=1 instance
      for (int i = 0; i < 9; i++) tbl[i] = '{1, 1, 0, 0, 0, i + 1, 0};
      tbl[9]  = '{1, 1, 0, 0, 0,  0, 1};
      tbl[10] = '{1, 1, 0, 1, 12, 9, 0};
      tbl[11] = '{1, 1, 1, 0, 0,  0, 0};
      tbl[12] = '{0, 1, 0, 1, 3,  3, 0};
      tbl[13] = '{1, 0, 0, 0, 0,  2, 0};
      tbl[14] = '{0, 0, 0, 0, 0,  2, 0};
      tbl[15] = '{0, 0, 0, 1, 0,  0, 0};
      tbl[16] = '{1, 0, 0, 0, 0,  9, 1};
      tbl[17] = '{1, 1, 0, 0, 0,  0, 1};
      tbl[18] = '{0, 1, 0, 1, 9,  9, 0};
      tbl[19] = '{1, 1, 0, 1, 4,  4, 0};

      KEY0 = 1'b1; KEY1 = 1'b1; cnt_en = 1'b0; up = 1'b1;
      clear = 1'b0; load = 1'b0; load_value = 4'd0;
      #1 KEY0 = 1'b0;
      #1;
      chk("rst_value",   32'(v0), 32'd0);
      chk("rst_carry",   32'(c0), 32'd0);
      chk("rst_seg",     32'(s0), 32'h01);
      chk("rst_running", 32'(r0), 32'd1);
      chk_on = 1'b1;
      tick();
      KEY0 = 1'b1;

      for (int i = 0; i < 20; i++) begin
         cnt_en = tbl[i].en; up = tbl[i].upd; clear = tbl[i].clr;
         load = tbl[i].ld; load_value = 4'(tbl[i].lv);
         tick();
         chk("tbl_value", 32'(v0), 32'(tbl[i].ev));
         chk("tbl_carry", 32'(c0), 32'(tbl[i].ec));
         chk("tbl_seg",   32'(s0), 32'(seg_of(tbl[i].ev)));
      end
      clear = 1'b0; load = 1'b0;

      // down count from 0 on the MODULUS=6 instance
      clear = 1'b1; cnt_en = 1'b0;
      tick();
      clear = 1'b0; cnt_en = 1'b1; up = 1'b0;
      tick();
      chk("down_wrap_value", 32'(v1), 32'd5);
      chk("down_wrap_carry", 32'(c1), 32'd1);
      tick();
      chk("down_value4", 32'(v1), 32'd4);
      chk("down_carry0", 32'(c1), 32'd0);
      tick();
      chk("down_value3", 32'(v1), 32'd3);

      // DIV=4 instance with cnt_en on alternating cycles
      up = 1'b1; clear = 1'b1; cnt_en = 1'b0;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cnt_en = (i % 2 == 0);
         tick();
         if (i == 5)  chk("div_three_ticks", 32'(v2), 32'd0);
         if (i == 7)  chk("div_first_step",  32'(v2), 32'd1);
         if (i == 15) chk("div_second_step", 32'(v2), 32'd2);
      end

      // pause mid-prescale, then resume without losing the two pending ticks
      cnt_en = 1'b1;
      tick();
      tick();
      cnt_en = 1'b0; KEY1 = 1'b0;
      repeat (3) tick();
      chk("pause_running", 32'(r2), 32'd0);
      KEY1 = 1'b1; cnt_en = 1'b1;
      repeat (10) tick();
      chk("pause_hold_value", 32'(v2), 32'd2);
      chk("pause_still",      32'(r2), 32'd0);
      cnt_en = 1'b0; KEY1 = 1'b0;
      repeat (3) tick();
      chk("resume_running", 32'(r2), 32'd1);
      KEY1 = 1'b1; cnt_en = 1'b1;
      tick();
      chk("resume_third_tick", 32'(v2), 32'd2);
      tick();
      chk("resume_fourth_tick", 32'(v2), 32'd3);

      // button held low for 50 cycles toggles once, three edges after the press
      cnt_en = 1'b0; KEY1 = 1'b0;
      tick();
      chk("hold_edge1", 32'(r0), 32'd1);
      tick();
      chk("hold_edge2", 32'(r0), 32'd1);
      tick();
      chk("hold_edge3", 32'(r0), 32'd0);
      repeat (47) tick();
      chk("hold_end", 32'(r0), 32'd0);
      KEY1 = 1'b1;
      repeat (5) tick();
      chk("hold_release", 32'(r0), 32'd0);
      KEY1 = 1'b0;
      repeat (3) tick();
      chk("hold_rerun", 32'(r0), 32'd1);
      KEY1 = 1'b1;
      repeat (3) tick();

      // asynchronous reset while paused at 7
      load = 1'b1; load_value = 4'd6;
      tick();
      load = 1'b0; cnt_en = 1'b1; up = 1'b1;
      tick();
      chk("pre_reset_value", 32'(v0), 32'd7);
      cnt_en = 1'b0; KEY1 = 1'b0;
      repeat (4) tick();
      chk("pre_reset_paused", 32'(r0), 32'd0);
      KEY0 = 1'b0;
      #1;
      chk("async_rst_value",   32'(v0), 32'd0);
      chk("async_rst_carry",   32'(c0), 32'd0);
      chk("async_rst_seg",     32'(s0), 32'h01);
      chk("async_rst_running", 32'(r0), 32'd1);
      KEY1 = 1'b1;
      tick();
      KEY0 = 1'b1;
      tick();

      // randomized traffic against the model
      repeat (3000) begin
         cnt_en     = 1'($urandom_range(0, 1));
         up         = 1'($urandom_range(0, 1));
         clear      = ($urandom_range(0, 15) == 0);
         load       = ($urandom_range(0, 15) == 0);
         load_value = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) KEY1 = ~KEY1;
         if ($urandom_range(0, 199) == 0) begin
            KEY0 = 1'b0;
            #2 KEY0 = 1'b1;
         end
         tick();
      end

      chk_on = 1'b0;
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/digit_counter_7seg.md
# digit_counter_7seg

Parametrised single-digit counter with pause and 7-segment output. Counts enabled ticks through a programmable divider, wraps at MODULUS, supports up/down direction, load and synchronous clear, and drives an active-low seven-segment digit plus a one-cycle carry/borrow pulse. Instances chain, carry into `cnt_en` of the next, to build multi-digit clocks and stopwatches (seconds units/tens, minutes, ...).

## Interface
Parameters:
- `MODULUS`, 10: count range 0..MODULUS-1; legal 2..16.
- `DIV`, 1: enabled ticks per step; legal 1..2^24.
- `WIDTH`, derived localparam = 4: value width; not overridable.

Ports:
- `clock`  in  1  sole clock; all state rises on posedge.
- `KEY0`  in  1  reset, asynchronous, active-low.
- `KEY1`  in  1  pause/run button, active-low, asynchronous; synchronised internally.
- `cnt_en`  in  1  tick enable / carry-in from lower digit; synchronous.
- `up`  in  1  1 = count up, 0 = count down.
- `clear`  in  1  synchronous clear to 0.
- `load`  in  1  synchronous load of `load_value`.
- `load_value`  in  4  value to load; values >= MODULUS are clamped to MODULUS-1.
- `value`  out  4  current digit.
- `carry`  out  1  one-cycle pulse on wrap (up: MODULUS-1→0; down: 0→MODULUS-1).
- `running`  out  1  1 in RUN state.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`  out  1 each  segments, active-low (0 = lit).

## Operation
- FSM states: RUN, PAUSE. Reset → RUN.
- KEY1 passes through a 2-flop synchroniser; a falling edge of the synchronised signal (press) toggles RUN↔PAUSE. Held button toggles only once.
- Priority per cycle: reset > clear > load > step.
- `clear`: value←0, prescaler←0, carry←0; allowed in any state; state unchanged.
- `load`: value←min(load_value, MODULUS-1), prescaler←0, carry←0; any state.
- Step: only in RUN with `cnt_en`=1. Prescaler increments; when prescaler==DIV-1 it returns to 0 and value steps ±1 by `up`.
- Wrap: up from MODULUS-1 gives 0 with carry=1; down from 0 gives MODULUS-1 with carry=1. All other cycles carry=0.
- PAUSE: prescaler and value hold; `cnt_en` ignored; carry=0.
- Changing `up` mid-count does not reset the prescaler.
- Segment decode, active-low: 0→g only dark; 1→b,c lit; 2→a,b,d,e,g; 3→a,b,c,d,g; 4→b,c,f,g; 5→a,c,d,f,g; 6→a,c,d,e,f,g; 7→a,b,c; 8→all lit; 9→a,b,c,d,f,g; A–F in standard hex glyphs for MODULUS>10.

## Timing
- Reset values (asynchronous, while KEY0=0): value=0, prescaler=0, carry=0, running=1, state RUN, synchroniser flops=1, segments show "0" (a–f=0, g=1).
- Release of KEY0 is synchronised by the consumer; the block counts from the first posedge after deassertion.
- value, carry and segments are registered and change on the same edge; segments are decoded from next-value, with no extra cycle of latency.
- Step latency: with DIV=1 value changes on the edge sampling `cnt_en`=1; with DIV=N, on the Nth enabled edge.
- KEY1 press to `running` change: 3 clock edges (2 sync + edge detect).
- Reset mid-count: immediate, asynchronous return to reset values; any pending toggle is discarded.
- Clear/load coincident with a wrap step: clear/load wins, carry=0.

## Structure
- Package `digit_pkg`: state enum (RUN, PAUSE), 16-entry active-low segment constant table (0–F, bit order a..g).
- Sub-module `seg7_decode`: combinational 4-bit → a..g lookup from the package table; instantiated once on next-value.
- Top holds the synchroniser, edge detect, FSM, prescaler and digit register.

## Test plan
- Reset: KEY0=0 mid-count at value 7 → value=0, carry=0, segments a–f=0, g=1, running=1, immediately (asynchronously).
- MODULUS=10, DIV=1, up=1, cnt_en=1 for 10 cycles → value 1..9,0; carry=1 only on the 9→0 edge; segments match each digit.
- Down count from 0 with MODULUS=6 → value 5 and carry=1 on that edge, then 4,3,...
- DIV=4, cnt_en high on alternating cycles → one step per 8 clocks; PAUSE via KEY1 press mid-prescale holds value and prescaler, and counting resumes with no lost tick after a second press.
- KEY1 held low 50 cycles → single toggle, and running=0 exactly 3 edges after the press.
- Load 12 with MODULUS=10 → value=9; clear asserted together with a 9→0 wrap → value=0, carry=0.
